// File: rtl/mul8_seq_ctrl.sv
// Sequencing controller: computes one 8x8 unsigned product by driving a shared
// external 4x4 multiplier core over four passes and accumulating the shifted
// partial products.
// Latency: out_valid rises 4 cycles after the acceptance edge; throughput is
// one product per 5 cycles when back-to-back.
// Backpressure: O/out_valid are held in DONE until out_ready; in_ready is low
// while busy except in DONE, where it follows out_ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (A, B sampled at the handshake)
//   out_valid/out_ready  result handshake (O = A*B)
//   busy                 high in MUL or DONE
//   core_a/core_b        nibbles to the shared 4x4 core
//   core_p               combinational core product, sampled the same cycle
module mul8_seq_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  O,
  output logic            busy,
  output logic [CW-1:0]   core_a,
  output logic [CW-1:0]   core_b,
  input  logic [2*CW-1:0] core_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     k_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] o_q;
  logic           ov_q;

  logic [2*W-1:0] pp_ext;
  logic [2*W-1:0] acc_d;
  logic           accept;

  // in_ready depends only on state, out_ready and rst, never on in_valid.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = ov_q;
  assign O         = o_q;
  assign busy      = (state_q != IDLE);

  // Pass schedule: k[0] selects the A nibble, k[1] selects the B nibble.
  always_comb begin
    core_a = '0;
    core_b = '0;
    if (state_q == MUL) begin
      core_a = k_q[0] ? a_q[W-1:CW] : a_q[CW-1:0];
      core_b = k_q[1] ? b_q[W-1:CW] : b_q[CW-1:0];
    end
  end

  // Partial product weight: 2^0 for k=0, 2^4 for the cross terms, 2^8 for k=3.
  always_comb begin
    pp_ext = {{(2*W-2*CW){1'b0}}, core_p};
    acc_d  = acc_q;
    unique case (k_q)
      2'd0:    acc_d = acc_q + pp_ext;
      2'd1,
      2'd2:    acc_d = acc_q + (pp_ext << CW);
      default: acc_d = acc_q + (pp_ext << (2*CW));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          k_q   <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            o_q     <= acc_d;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_q <= 1'b0;
            // Retiring the result and accepting new operands can share an edge.
            if (accept) begin
              a_q     <= A;
              b_q     <= B;
              acc_q   <= '0;
              k_q     <= '0;
              state_q <= MUL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
